// File: rtl/ipv4_hdr_capture_ctrl.sv
// ipv4_hdr_capture_ctrl: captures IPv4 header fields from a 16-bit word stream,
// checks version/IHL/checksum and presents the result with a valid/ack handshake.
module ipv4_hdr_capture_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        hdr_valid,
    input  logic        out_ack,
    output logic        hdr_ok,
    output logic [1:0]  err_code,
    output logic [3:0]  ihl,
    output logic [15:0] total_len,
    output logic [7:0]  ttl,
    output logic [7:0]  proto,
    output logic [31:0] src_addr,
    output logic [31:0] dst_addr
);
    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, HOLD} state_t;
    state_t      state;
    logic [3:0]  ver;
    logic [4:0]  wcnt;
    logic [15:0] acc;
    logic [16:0] sum;
    logic [4:0]  last_idx;
    logic        xfer;
    assign xfer = in_valid & in_ready;
    assign sum = {1'b0, acc} + {1'b0, in_data};
    // an illegal IHL still consumes a 20-byte header
    assign last_idx = (ihl >= 4'd5) ? {ihl, 1'b0} - 5'd1 : 5'd9;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            hdr_valid <= 1'b0;
            hdr_ok    <= 1'b0;
            err_code  <= 2'd0;
            ver       <= 4'd0;
            ihl       <= 4'd0;
            wcnt      <= 5'd0;
            acc       <= 16'd0;
            total_len <= 16'd0;
            ttl       <= 8'd0;
            proto     <= 8'd0;
            src_addr  <= 32'd0;
            dst_addr  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        ver   <= in_data[15:12];
                        ihl   <= in_data[11:8];
                        wcnt  <= 5'd1;
                        acc   <= in_data;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (xfer) begin
                        acc  <= sum[15:0] + {15'd0, sum[16]};
                        wcnt <= wcnt + 5'd1;
                        if (wcnt == 5'd1) total_len <= in_data;
                        if (wcnt == 5'd4) {ttl, proto} <= in_data;
                        if (wcnt == 5'd6) src_addr[31:16] <= in_data;
                        if (wcnt == 5'd7) src_addr[15:0] <= in_data;
                        if (wcnt == 5'd8) dst_addr[31:16] <= in_data;
                        if (wcnt == 5'd9) dst_addr[15:0] <= in_data;
                        if (wcnt == last_idx) begin
                            in_ready <= 1'b0;
                            state    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    err_code  <= (ver != 4'd4) ? 2'd1 : (ihl < 4'd5) ? 2'd2 : (acc != 16'hFFFF) ? 2'd3 : 2'd0;
                    hdr_ok    <= (ver == 4'd4) && (ihl >= 4'd5) && (acc == 16'hFFFF);
                    hdr_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ack) begin
                        hdr_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipv4_hdr_capture_ctrl.sv
// tb_ipv4_hdr_capture_ctrl: directed checks of header capture, validation and handshake.
module tb_ipv4_hdr_capture_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        out_ack = 1'b0;
    logic        in_ready, hdr_valid, hdr_ok;
    logic [1:0]  err_code;
    logic [3:0]  ihl;
    logic [15:0] total_len;
    logic [7:0]  ttl, proto;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] hdr [0:11];
    int total = 0;
    int bad = 0;

    ipv4_hdr_capture_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hdr_valid(hdr_valid), .out_ack(out_ack),
        .hdr_ok(hdr_ok), .err_code(err_code), .ihl(ihl), .total_len(total_len),
        .ttl(ttl), .proto(proto), .src_addr(src_addr), .dst_addr(dst_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 40 && !in_ready; i++) step();
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 16'd0;
    endtask

    task automatic send_hdr(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) repeat ($urandom_range(0, 2)) step();
            send(hdr[k]);
        end
    endtask

    task automatic load_good();
        hdr = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'hB861,
                16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7, 16'h0000, 16'h0000};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_hdr_valid"}, {31'd0, hdr_valid}, 32'd0);
        chk({tag, "_hdr_ok"}, {31'd0, hdr_ok}, 32'd0);
        chk({tag, "_err"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_ihl"}, {28'd0, ihl}, 32'd0);
        chk({tag, "_len"}, {16'd0, total_len}, 32'd0);
        chk({tag, "_ttl_proto"}, {16'd0, ttl, proto}, 32'd0);
        chk({tag, "_src"}, src_addr, 32'd0);
        chk({tag, "_dst"}, dst_addr, 32'd0);
    endtask

    task automatic chk_hdr(input string tag, input logic [1:0] err, input logic [3:0] ih);
        chk({tag, "_hdr_valid"}, {31'd0, hdr_valid}, 32'd1);
        chk({tag, "_err"}, {30'd0, err_code}, {30'd0, err});
        chk({tag, "_hdr_ok"}, {31'd0, hdr_ok}, {31'd0, err == 2'd0});
        chk({tag, "_ihl"}, {28'd0, ihl}, {28'd0, ih});
        chk({tag, "_len"}, {16'd0, total_len}, 32'h0000_0073);
        chk({tag, "_ttl_proto"}, {16'd0, ttl, proto}, 32'h0000_4011);
        chk({tag, "_src"}, src_addr, 32'hC0A8_0001);
        chk({tag, "_dst"}, dst_addr, 32'hC0A8_00C7);
    endtask

    // assumes out_ack=1: CHECK cycle, one-cycle hdr_valid, then back to IDLE
    task automatic finish_hdr(input string tag, input logic [1:0] err, input logic [3:0] ih);
        chk({tag, "_check_valid"}, {31'd0, hdr_valid}, 32'd0);
        chk({tag, "_check_ready"}, {31'd0, in_ready}, 32'd0);
        step();
        chk_hdr(tag, err, ih);
        chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        step();
        chk({tag, "_ack_valid"}, {31'd0, hdr_valid}, 32'd0);
        chk({tag, "_ack_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1 reset = 1'b0;
        #11;
        chk_zero("reset");
        step();
        chk_zero("reset_edge");
        @(negedge clk) reset = 1'b1;
        step();
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        out_ack = 1'b1;

        load_good();
        send_hdr(10, 1'b0);
        finish_hdr("good", 2'd0, 4'd5);

        hdr[5] = 16'hB862;
        send_hdr(10, 1'b0);
        finish_hdr("badcs", 2'd3, 4'd5);

        load_good();
        hdr[0] = 16'h6500;
        send_hdr(10, 1'b0);
        finish_hdr("ver6", 2'd1, 4'd5);
        hdr[0] = 16'h4300;
        send_hdr(10, 1'b0);
        finish_hdr("ihl3", 2'd2, 4'd3);
        hdr[0] = 16'h6300;
        send_hdr(10, 1'b0);
        finish_hdr("v6ihl3", 2'd1, 4'd3);

        load_good();
        hdr[0]  = 16'h4600;
        hdr[5]  = 16'hB761;
        hdr[10] = 16'h0000;
        hdr[11] = 16'h0000;
        send_hdr(12, 1'b0);
        finish_hdr("ihl6", 2'd0, 4'd6);

        out_ack = 1'b0;
        load_good();
        send_hdr(10, 1'b1);
        chk("gap_check_valid", {31'd0, hdr_valid}, 32'd0);
        step();
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        repeat (5) begin
            chk_hdr("hold", 2'd0, 4'd5);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ack  = 1'b1;
        step();
        chk("hold_ack_valid", {31'd0, hdr_valid}, 32'd0);
        chk("hold_ack_ready", {31'd0, in_ready}, 32'd1);
        chk("hold_keep_len", {16'd0, total_len}, 32'h0000_0073);
        send_hdr(10, 1'b0);
        finish_hdr("after_hold", 2'd0, 4'd5);

        hdr[0] = 16'h4700;
        for (int k = 0; k < 5; k++) send(hdr[k]);
        #2 reset = 1'b0;
        #1;
        chk_zero("mid_reset");
        step();
        chk_zero("mid_reset_edge");
        @(negedge clk) reset = 1'b1;
        step();
        chk("rerelease_ready", {31'd0, in_ready}, 32'd1);
        load_good();
        send_hdr(10, 1'b0);
        finish_hdr("post_reset", 2'd0, 4'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
